// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared encodings and helpers for the snake game controller
package snake_pkg;

    localparam int GRID_W = 3;

    typedef logic [GRID_W-1:0] coord_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_OVER = 2'b10
    } state_t;

    localparam dir_t DIR_INIT = DIR_DOWN;

    // x^8 + x^6 + x^5 + x^4 + 1, feedback taken from bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic lfsr_fb(input logic [7:0] v);
        return ^(v & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/snake_game_ctrl_if.sv
// rtl/snake_game_ctrl_if.sv - controller <-> buttons/snake_body signal bundle
interface snake_game_ctrl_if;
    import snake_pkg::*;

    logic               btn_up;
    logic               btn_down;
    logic               btn_left;
    logic               btn_right;
    logic               btn_start;
    logic [GRID_W-1:0]  head_x;
    logic [GRID_W-1:0]  head_y;
    logic [GRID_W-1:0]  body1_x;
    logic [GRID_W-1:0]  body1_y;
    logic [GRID_W-1:0]  body2_x;
    logic [GRID_W-1:0]  body2_y;
    logic               move_enable;
    logic [1:0]         direction;
    logic               grow;
    logic [GRID_W-1:0]  food_x;
    logic [GRID_W-1:0]  food_y;
    logic               food_valid;
    logic [7:0]         score;
    logic               game_over;
    logic [1:0]         state;
    logic               snake_restart;

    // controller side
    modport master (
        input  btn_up, btn_down, btn_left, btn_right, btn_start,
        input  head_x, head_y, body1_x, body1_y, body2_x, body2_y,
        output move_enable, direction, grow, food_x, food_y, food_valid,
        output score, game_over, state, snake_restart
    );

    // buttons + snake_body side
    modport slave (
        output btn_up, btn_down, btn_left, btn_right, btn_start,
        output head_x, head_y, body1_x, body1_y, body2_x, body2_y,
        input  move_enable, direction, grow, food_x, food_y, food_valid,
        input  score, game_over, state, snake_restart
    );

endinterface

// File: rtl/snake_food_gen.sv
// rtl/snake_food_gen.sv - LFSR food placement avoiding the snake segments
module snake_food_gen
    import snake_pkg::*;
#(
    parameter logic [GRID_W-1:0] FOOD_X0   = 3'd2,
    parameter logic [GRID_W-1:0] FOOD_Y0   = 3'd6,
    parameter logic [7:0]        LFSR_SEED = 8'hA5
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   i_consume,
    input  logic   i_restart,
    input  coord_t i_head_x,
    input  coord_t i_head_y,
    input  coord_t i_body1_x,
    input  coord_t i_body1_y,
    input  coord_t i_body2_x,
    input  coord_t i_body2_y,
    output coord_t o_food_x,
    output coord_t o_food_y,
    output logic   o_food_valid
);

    logic [7:0] r_lfsr;
    logic       r_hold;
    coord_t     r_food_x;
    coord_t     r_food_y;
    logic       r_food_valid;

    coord_t     w_cand_x;
    coord_t     w_cand_y;
    logic       w_cand_ok;

    assign w_cand_x = r_lfsr[2:0];
    assign w_cand_y = r_lfsr[5:3];

    // candidate must not sit on any visible segment
    always_comb begin
        w_cand_ok = 1'b1;
        if (w_cand_x == i_head_x  && w_cand_y == i_head_y)  w_cand_ok = 1'b0;
        if (w_cand_x == i_body1_x && w_cand_y == i_body1_y) w_cand_ok = 1'b0;
        if (w_cand_x == i_body2_x && w_cand_y == i_body2_y) w_cand_ok = 1'b0;
    end

    // free-running LFSR; food cleared on consume, re-placed once segments have moved
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr       <= LFSR_SEED;
            r_hold       <= 1'b0;
            r_food_x     <= FOOD_X0;
            r_food_y     <= FOOD_Y0;
            r_food_valid <= 1'b1;
        end else begin
            r_lfsr <= {r_lfsr[6:0], lfsr_fb(r_lfsr)};
            if (i_restart) begin
                r_hold       <= 1'b0;
                r_food_x     <= FOOD_X0;
                r_food_y     <= FOOD_Y0;
                r_food_valid <= 1'b1;
            end else if (i_consume) begin
                // the move pulse is still in flight: segments are stale for one cycle
                r_hold       <= 1'b1;
                r_food_valid <= 1'b0;
            end else begin
                r_hold <= 1'b0;
                if (!r_food_valid && !r_hold && w_cand_ok) begin
                    r_food_x     <= w_cand_x;
                    r_food_y     <= w_cand_y;
                    r_food_valid <= 1'b1;
                end
            end
        end
    end

    assign o_food_x     = r_food_x;
    assign o_food_y     = r_food_y;
    assign o_food_valid = r_food_valid;

endmodule

// File: rtl/snake_game_ctrl.sv
// rtl/snake_game_ctrl.sv - snake game FSM, move prescaler, steering, collision and score
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int                TICK_DIV  = 12500000,
    parameter int                WRAP      = 1,
    parameter logic [GRID_W-1:0] FOOD_X0   = 3'd2,
    parameter logic [GRID_W-1:0] FOOD_Y0   = 3'd6,
    parameter logic [7:0]        LFSR_SEED = 8'hA5
) (
    input  logic               clk,
    input  logic               reset,
    snake_game_ctrl_if.master  bus
);

    localparam int                CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);

    state_t            r_state;
    dir_t              r_dir;
    dir_t              r_pend;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_move;
    logic              r_grow;
    logic              r_restart;
    logic              r_over;
    logic [7:0]        r_score;

    logic              w_tick;
    dir_t              w_nd;
    coord_t            w_nh_x;
    coord_t            w_nh_y;
    logic              w_wall;
    logic              w_eat;
    logic              w_coll;
    logic              w_consume;
    logic              w_restart;
    coord_t            w_food_x;
    coord_t            w_food_y;
    logic              w_food_valid;

    assign w_tick = (r_state == ST_RUN) && (r_cnt == CNT_LAST);

    // reversal filter against the committed direction, then step the head one cell
    always_comb begin
        w_nd = r_pend;
        if (r_pend[1] == r_dir[1] && r_pend[0] != r_dir[0]) w_nd = r_dir;
        w_nh_x = bus.head_x;
        w_nh_y = bus.head_y;
        w_wall = 1'b0;
        case (w_nd)
            DIR_UP: begin
                w_nh_y = bus.head_y - coord_t'(1);
                w_wall = (bus.head_y == coord_t'(0));
            end
            DIR_DOWN: begin
                w_nh_y = bus.head_y + coord_t'(1);
                w_wall = (bus.head_y == coord_t'(7));
            end
            DIR_LEFT: begin
                w_nh_x = bus.head_x - coord_t'(1);
                w_wall = (bus.head_x == coord_t'(0));
            end
            DIR_RIGHT: begin
                w_nh_x = bus.head_x + coord_t'(1);
                w_wall = (bus.head_x == coord_t'(7));
            end
        endcase
        if (WRAP != 0) w_wall = 1'b0;
    end

    // tail cell only stays occupied when this move grows the snake
    assign w_eat     = w_food_valid && (w_nh_x == w_food_x) && (w_nh_y == w_food_y);
    assign w_coll    = w_wall
                     || (w_nh_x == bus.body1_x && w_nh_y == bus.body1_y)
                     || (w_eat && w_nh_x == bus.body2_x && w_nh_y == bus.body2_y);
    assign w_consume = w_tick && !w_coll && w_eat;
    assign w_restart = (r_state == ST_OVER) && bus.btn_start;

    // game FSM with registered pulses, prescaler, steering and score
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_dir     <= DIR_INIT;
            r_pend    <= DIR_INIT;
            r_cnt     <= '0;
            r_move    <= 1'b0;
            r_grow    <= 1'b0;
            r_restart <= 1'b0;
            r_over    <= 1'b0;
            r_score   <= 8'd0;
        end else begin
            r_move    <= 1'b0;
            r_grow    <= 1'b0;
            r_restart <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.btn_start) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    if      (bus.btn_up)    r_pend <= DIR_UP;
                    else if (bus.btn_down)  r_pend <= DIR_DOWN;
                    else if (bus.btn_left)  r_pend <= DIR_LEFT;
                    else if (bus.btn_right) r_pend <= DIR_RIGHT;
                    r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
                    if (w_tick) begin
                        if (w_coll) begin
                            r_state <= ST_OVER;
                            r_over  <= 1'b1;
                        end else begin
                            r_move <= 1'b1;
                            r_dir  <= w_nd;
                            r_grow <= w_eat;
                            if (w_eat && r_score != 8'hFF) r_score <= r_score + 8'd1;
                        end
                    end
                end
                ST_OVER: begin
                    if (bus.btn_start) begin
                        r_state   <= ST_IDLE;
                        r_restart <= 1'b1;
                        r_over    <= 1'b0;
                        r_score   <= 8'd0;
                        r_dir     <= DIR_INIT;
                        r_pend    <= DIR_INIT;
                        r_cnt     <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    snake_food_gen #(
        .FOOD_X0   (FOOD_X0),
        .FOOD_Y0   (FOOD_Y0),
        .LFSR_SEED (LFSR_SEED)
    ) u_food (
        .clk          (clk),
        .reset        (reset),
        .i_consume    (w_consume),
        .i_restart    (w_restart),
        .i_head_x     (bus.head_x),
        .i_head_y     (bus.head_y),
        .i_body1_x    (bus.body1_x),
        .i_body1_y    (bus.body1_y),
        .i_body2_x    (bus.body2_x),
        .i_body2_y    (bus.body2_y),
        .o_food_x     (w_food_x),
        .o_food_y     (w_food_y),
        .o_food_valid (w_food_valid)
    );

    assign bus.move_enable   = r_move;
    assign bus.direction     = r_dir;
    assign bus.grow          = r_grow;
    assign bus.food_x        = w_food_x;
    assign bus.food_y        = w_food_y;
    assign bus.food_valid    = w_food_valid;
    assign bus.score         = r_score;
    assign bus.game_over     = r_over;
    assign bus.state         = r_state;
    assign bus.snake_restart = r_restart;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb/tb_snake_game_ctrl.sv - directed scoreboard bench, two controllers with snake_body models
module tb_snake_game_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    logic       t_up[2], t_down[2], t_left[2], t_right[2], t_start[2];
    logic       ob_me[2], ob_grow[2], ob_fv[2], ob_over[2], ob_rst[2];
    logic [1:0] ob_dir[2], ob_st[2];
    logic [2:0] ob_fx[2], ob_fy[2];
    logic [7:0] ob_sc[2];
    logic [2:0] m_hx[2], m_hy[2], m_b1x[2], m_b1y[2], m_b2x[2], m_b2y[2];

    function automatic logic [5:0] step(input logic [2:0] x, input logic [2:0] y, input logic [1:0] d);
        logic [2:0] nx, ny;
        nx = x; ny = y;
        case (d)
            2'b00: ny = y - 3'd1;
            2'b01: ny = y + 3'd1;
            2'b10: nx = x - 3'd1;
            default: nx = x + 3'd1;
        endcase
        return {nx, ny};
    endfunction

    // instance 0: WRAP=1, food (4,6); instance 1: WRAP=0, food (2,6)
    for (genvar g = 0; g < 2; g++) begin : gen_i
        snake_game_ctrl_if bus();
        logic [2:0] hx, hy, b1x, b1y, b2x, b2y;
        wire w_brst = reset | bus.snake_restart;

        assign bus.btn_up    = t_up[g];
        assign bus.btn_down  = t_down[g];
        assign bus.btn_left  = t_left[g];
        assign bus.btn_right = t_right[g];
        assign bus.btn_start = t_start[g];
        assign bus.head_x  = hx;  assign bus.head_y  = hy;
        assign bus.body1_x = b1x; assign bus.body1_y = b1y;
        assign bus.body2_x = b2x; assign bus.body2_y = b2y;
        assign m_hx[g] = hx;   assign m_hy[g] = hy;
        assign m_b1x[g] = b1x; assign m_b1y[g] = b1y;
        assign m_b2x[g] = b2x; assign m_b2y[g] = b2y;
        assign ob_me[g]   = bus.move_enable;
        assign ob_grow[g] = bus.grow;
        assign ob_fv[g]   = bus.food_valid;
        assign ob_over[g] = bus.game_over;
        assign ob_rst[g]  = bus.snake_restart;
        assign ob_dir[g]  = bus.direction;
        assign ob_st[g]   = bus.state;
        assign ob_fx[g]   = bus.food_x;
        assign ob_fy[g]   = bus.food_y;
        assign ob_sc[g]   = bus.score;

        snake_game_ctrl #(
            .TICK_DIV  (4),
            .WRAP      ((g == 0) ? 1 : 0),
            .FOOD_X0   ((g == 0) ? 3'd4 : 3'd2),
            .FOOD_Y0   (3'd6),
            .LFSR_SEED (8'hA5)
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );

        // snake_body stand-in: head (4,4) facing down, shift on each move pulse
        always_ff @(posedge clk or posedge w_brst) begin
            if (w_brst) begin
                {hx, hy}   <= {3'd4, 3'd4};
                {b1x, b1y} <= {3'd4, 3'd3};
                {b2x, b2y} <= {3'd4, 3'd2};
            end else if (bus.move_enable) begin
                {hx, hy}   <= step(hx, hy, bus.direction);
                {b1x, b1y} <= {hx, hy};
                {b2x, b2y} <= {b1x, b1y};
            end
        end
    end

    // record the first food re-placement on instance 0 and whether it avoided the snake
    logic placed = 1'b0;
    logic place_ok = 1'b0;
    logic fv_prev = 1'b1;
    always @(negedge clk) begin
        if (!reset && !fv_prev && ob_fv[0] && !placed) begin
            placed   = 1'b1;
            place_ok = !((ob_fx[0] == m_hx[0]  && ob_fy[0] == m_hy[0])  ||
                         (ob_fx[0] == m_b1x[0] && ob_fy[0] == m_b1y[0]) ||
                         (ob_fx[0] == m_b2x[0] && ob_fy[0] == m_b2y[0]));
        end
        fv_prev = ob_fv[0];
    end

    typedef struct {
        logic [1:0] dir;
        logic       grow;
        logic       chk_grow;
        logic [2:0] hx;
        logic [2:0] hy;
        logic [7:0] score;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] d, input logic gr, input logic cg,
                        input logic [2:0] x, input logic [2:0] y, input logic [7:0] sc);
        exp_t e;
        e.dir = d; e.grow = gr; e.chk_grow = cg; e.hx = x; e.hy = y; e.score = sc;
        sb.push_back(e);
    endtask

    // pulse one button for exactly one cycle; called at a negedge
    task automatic press(input int g, input int which, output int c0);
        c0 = cyc;
        case (which)
            0: t_up[g] = 1'b1;
            1: t_down[g] = 1'b1;
            2: t_left[g] = 1'b1;
            3: t_right[g] = 1'b1;
            default: t_start[g] = 1'b1;
        endcase
        @(negedge clk);
        t_up[g] = 1'b0; t_down[g] = 1'b0; t_left[g] = 1'b0;
        t_right[g] = 1'b0; t_start[g] = 1'b0;
    endtask

    // wait for the next move pulse, compare against the scoreboard head entry
    task automatic do_move(input int g, input int ref_c, input int exp_d, output int pulse_c);
        exp_t e;
        bit   seen;
        seen = 0;
        pulse_c = cyc;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (ob_me[g]) seen = 1;
        end
        e = sb.pop_front();
        if (!seen) begin
            chk("move_timeout", 32'd0, 32'd1);
        end else begin
            pulse_c = cyc;
            chk("move_period", pulse_c - ref_c, exp_d);
            chk("move_dir", ob_dir[g], e.dir);
            if (e.chk_grow) begin
                chk("move_grow", ob_grow[g], e.grow);
                if (e.grow) begin
                    chk("eat_score", ob_sc[g], e.score);
                    chk("eat_food_valid", ob_fv[g], 1'b0);
                end
            end
            @(negedge clk);
            chk("head_after_move", {m_hx[g], m_hy[g]}, {e.hx, e.hy});
        end
    endtask

    task automatic check_reset(input int g, input logic [2:0] fx);
        chk("rst_state", ob_st[g], 2'b00);
        chk("rst_dir", ob_dir[g], 2'b01);
        chk("rst_food", {ob_fx[g], ob_fy[g]}, {fx, 3'd6});
        chk("rst_food_valid", ob_fv[g], 1'b1);
        chk("rst_score", ob_sc[g], 8'd0);
        chk("rst_pulses", {ob_me[g], ob_grow[g], ob_rst[g], ob_over[g]}, 4'b0000);
    endtask

    initial begin
        int c0, p, dummy;
        bit moved;
        for (int i = 0; i < 2; i++) begin
            t_up[i] = 0; t_down[i] = 0; t_left[i] = 0; t_right[i] = 0; t_start[i] = 0;
        end
        repeat (3) @(negedge clk);
        check_reset(0, 3'd4);
        check_reset(1, 3'd2);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // instance 0: timing, eat, reversal reject, wrap, double turn
        push(2'b01, 1'b0, 1'b1, 3'd4, 3'd5, 8'd0);
        press(0, 4, c0);
        do_move(0, c0, 5, p);
        push(2'b01, 1'b1, 1'b1, 3'd4, 3'd6, 8'd1);
        do_move(0, p, 4, p);
        press(0, 0, dummy);
        push(2'b01, 1'b0, 1'b0, 3'd4, 3'd7, 8'd0);
        do_move(0, p, 4, p);
        push(2'b01, 1'b0, 1'b0, 3'd4, 3'd0, 8'd0);
        do_move(0, p, 4, p);
        press(0, 3, dummy);
        press(0, 2, dummy);
        push(2'b10, 1'b0, 1'b0, 3'd3, 3'd0, 8'd0);
        do_move(0, p, 4, p);
        chk("food_replaced", placed, 1'b1);
        chk("food_off_snake", place_ok, 1'b1);
        chk("run_state", ob_st[0], 2'b01);

        // asynchronous reset in the middle of a cycle while running
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_reset(0, 3'd4);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // instance 1: steer onto food, then hit the bottom wall
        push(2'b01, 1'b0, 1'b1, 3'd4, 3'd5, 8'd0);
        press(1, 4, c0);
        do_move(1, c0, 5, p);
        press(1, 2, dummy);
        push(2'b10, 1'b0, 1'b1, 3'd3, 3'd5, 8'd0);
        do_move(1, p, 4, p);
        push(2'b10, 1'b0, 1'b1, 3'd2, 3'd5, 8'd0);
        do_move(1, p, 4, p);
        press(1, 1, dummy);
        push(2'b01, 1'b1, 1'b1, 3'd2, 3'd6, 8'd1);
        do_move(1, p, 4, p);
        push(2'b01, 1'b0, 1'b0, 3'd2, 3'd7, 8'd0);
        do_move(1, p, 4, p);
        moved = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ob_me[1]) moved = 1;
        end
        chk("wall_no_move", moved, 1'b0);
        chk("wall_state", ob_st[1], 2'b10);
        chk("wall_game_over", ob_over[1], 1'b1);

        // restart from OVER
        press(1, 4, dummy);
        chk("restart_pulse", ob_rst[1], 1'b1);
        chk("restart_state", ob_st[1], 2'b00);
        chk("restart_score", ob_sc[1], 8'd0);
        chk("restart_dir", ob_dir[1], 2'b01);
        chk("restart_food", {ob_fx[1], ob_fy[1]}, {3'd2, 3'd6});
        chk("restart_food_valid", ob_fv[1], 1'b1);
        chk("restart_game_over", ob_over[1], 1'b0);
        @(negedge clk);
        chk("restart_pulse_end", ob_rst[1], 1'b0);
        chk("idle_hold", ob_st[1], 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
